// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: output modes,
// the reset half-period and the per-channel configuration record.
package clk_div_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  // 1 kHz output from the 100 MHz board clock
  localparam int unsigned DEFAULT_HALF_CYCLES = 50_000;
  localparam int unsigned CFG_HALF_W          = 16;

  typedef struct packed {
    logic [CFG_HALF_W-1:0] half;
    mode_e                 mode;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, shadow/active configuration
// registers and registered clock/tick outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = DEFAULT_HALF_CYCLES
) (
  input  logic             clk_fpga,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] half_sh;
  logic [CNT_W-1:0] cnt;
  mode_e            mode_q;
  mode_e            mode_sh;
  logic             clk_q;
  logic             tick_q;
  logic             active;
  logic             terminal;

  assign active   = en && (half_q != '0);
  assign terminal = (cnt == half_q - CNT_W'(1));

  // Shadow always takes writes; active regs change only when idle, at a
  // terminal count (with same-cycle write bypass) or on a sync restart.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      half_q  <= CNT_W'(DEFAULT_HALF);
      half_sh <= CNT_W'(DEFAULT_HALF);
      mode_q  <= MODE_CLOCK;
      mode_sh <= MODE_CLOCK;
      cnt     <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      if (cfg_we) begin
        half_sh <= cfg_half;
        mode_sh <= mode_e'(cfg_mode);
      end

      if (!active) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (cfg_we) begin
          half_q <= cfg_half;
          mode_q <= mode_e'(cfg_mode);
        end
      end else if (sync) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        half_q <= half_sh;
        mode_q <= mode_sh;
      end else if (terminal) begin
        cnt    <= '0;
        tick_q <= 1'b1;
        clk_q  <= (mode_q == MODE_CLOCK) ? ~clk_q : 1'b0;
        half_q <= cfg_we ? cfg_half : half_sh;
        mode_q <= cfg_we ? mode_e'(cfg_mode) : mode_sh;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        tick_q <= 1'b0;
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: decodes configuration writes to one channel
// and fans the phase-align request out to all of them.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = DEFAULT_HALF_CYCLES,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_fpga,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync_all,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  // Addresses beyond N_CH-1 match no channel and are dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_channel (
      .clk_fpga (clk_fpga),
      .rst      (rst),
      .en       (en[i]),
      .sync     (sync_all),
      .cfg_we   (ch_we),
      .cfg_half (cfg_half),
      .cfg_mode (cfg_mode),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a vector table for reprogramming
// timing plus hand-written sequences for pulse mode, sync, enable and reset.
module tb_clk_div_multi;

  localparam int TB_HALF = 20;

  typedef struct packed {
    logic [3:0]  en;
    logic        sync;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] half;
    logic        mode;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
  } vec_t;

  logic        clk_fpga;
  logic        rst;
  logic [3:0]  en;
  logic        sync_all;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_half;
  logic        cfg_mode;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int   checks   = 0;
  int   failures = 0;
  vec_t table_q[$];

  clk_div_multi #(
    .N_CH         (4),
    .CNT_W        (16),
    .DEFAULT_HALF (TB_HALF)
  ) dut (
    .clk_fpga (clk_fpga),
    .rst      (rst),
    .en       (en),
    .sync_all (sync_all),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .cfg_mode (cfg_mode),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  function automatic vec_t mk(logic [3:0] v_en, logic v_sync, logic v_we,
                              logic [1:0] v_ch, logic [15:0] v_half,
                              logic v_mode, logic [3:0] v_clk,
                              logic [3:0] v_tick);
    vec_t v;
    v.en       = v_en;
    v.sync     = v_sync;
    v.we       = v_we;
    v.ch       = v_ch;
    v.half     = v_half;
    v.mode     = v_mode;
    v.exp_clk  = v_clk;
    v.exp_tick = v_tick;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    en       = v.en;
    sync_all = v.sync;
    cfg_we   = v.we;
    cfg_ch   = v.ch;
    cfg_half = v.half;
    cfg_mode = v.mode;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_clk,
                             input logic [3:0] exp_tick);
    checks++;
    if (clk_out !== exp_clk || tick !== exp_tick) begin
      failures++;
      $display("[TB] FAIL %s: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
               name, clk_out, tick, exp_clk, exp_tick);
    end
  endtask

  // Expected outputs for the ch0/ch1 phase-align sequence, indexed by cycles after sync
  logic [3:0] sync_clk  [1:6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011};
  logic [3:0] sync_tick [1:6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

  initial begin
    // Reset with a simultaneous write to ch0 that must be discarded
    applyStimulus(mk(4'b1111, 1'b0, 1'b1, 2'd0, 16'd2, 1'b0, 4'b0, 4'b0));
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    applyStimulus(mk(4'b0000, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0));
    step();
    checkOutput("reset", 4'b0000, 4'b0000);

    // ch1: H=3 written while idle, H=5 written mid-period, then H=5 written at terminal
    table_q.push_back(mk(4'b0000, 0, 1, 2'd1, 16'd3, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0010));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0010));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 1, 2'd1, 16'd5, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0010));
    for (int k = 0; k < 4; k++)
      table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0010));
    for (int k = 0; k < 4; k++)
      table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0010));
    table_q.push_back(mk(4'b0010, 0, 1, 2'd1, 16'd3, 0, 4'b0010, 4'b0000));
    for (int k = 0; k < 3; k++)
      table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0010));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 1, 2'd1, 16'd5, 0, 4'b0010, 4'b0010));
    for (int k = 0; k < 4; k++)
      table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0010, 4'b0000));
    table_q.push_back(mk(4'b0010, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0010));

    foreach (table_q[i]) begin
      applyStimulus(table_q[i]);
      step();
      checkOutput($sformatf("row%0d", i), table_q[i].exp_clk, table_q[i].exp_tick);
    end

    // ch2 PULSE H=1, then CLOCK H=1 written at a terminal count
    applyStimulus(mk(4'b0000, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b0000, 0, 1, 2'd2, 16'd1, 1, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b0100, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("pulse_h1_%0d", k), 4'b0000, 4'b0100);
    end
    applyStimulus(mk(4'b0100, 0, 1, 2'd2, 16'd1, 0, 4'b0, 4'b0));
    step();
    checkOutput("mode_switch", 4'b0000, 4'b0100);
    applyStimulus(mk(4'b0100, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("clock_h1_%0d", k), (k % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0100);
    end

    // ch0 H=4 and ch1 H=6 free-running, then phase-aligned by sync_all
    applyStimulus(mk(4'b0000, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b0000, 0, 1, 2'd0, 16'd4, 0, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b0000, 0, 1, 2'd1, 16'd6, 0, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b0011, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    repeat (7) step();
    applyStimulus(mk(4'b0011, 1, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    step();
    checkOutput("sync_clear", 4'b0000, 4'b0000);
    applyStimulus(mk(4'b0011, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    for (int k = 1; k <= 6; k++) begin
      step();
      checkOutput($sformatf("sync_%0d", k), sync_clk[k], sync_tick[k]);
    end

    // ch3 H=4: drop en mid high phase
    applyStimulus(mk(4'b0000, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b0000, 0, 1, 2'd3, 16'd4, 0, 4'b0, 4'b0));
    step();
    applyStimulus(mk(4'b1000, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput($sformatf("en3_low_%0d", k), 4'b0000, 4'b0000);
    end
    step();
    checkOutput("en3_rise", 4'b1000, 4'b1000);
    step();
    checkOutput("en3_high", 4'b1000, 4'b0000);
    applyStimulus(mk(4'b0000, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    step();
    checkOutput("en3_drop", 4'b0000, 4'b0000);

    // Reset with write while channels run; ch0 must return to the default half-period
    applyStimulus(mk(4'b1111, 0, 1, 2'd0, 16'd2, 0, 4'b0, 4'b0));
    step();
    rst = 1'b1;
    step();
    checkOutput("rst_outputs", 4'b0000, 4'b0000);
    rst = 1'b0;
    applyStimulus(mk(4'b0001, 0, 0, 2'd0, 16'd0, 0, 4'b0, 4'b0));
    for (int k = 1; k <= 4 * TB_HALF; k++) begin
      step();
      checkOutput($sformatf("default_%0d", k),
                  ((k / TB_HALF) % 2 == 1) ? 4'b0001 : 4'b0000,
                  (k % TB_HALF == 0) ? 4'b0001 : 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider, generalising the fixed 100 MHz → 1 kHz divider. Produces N_CH independent divided outputs from `clk_fpga`. Each channel has a runtime-programmable half-period, a 50 %-duty clock output and a single-cycle tick output. Channels are individually enabled, reprogrammed glitch-free and phase-aligned on command. It sits between the board clock and the game's timing consumers: display scan, debounce, ball-speed and score timers.

## Interface
- `N_CH`, 4, number of channels (1..16)
- `CNT_W`, 16, counter / half-period width in bits
- `DEFAULT_HALF`, 50_000, reset half-period for every channel (1 kHz at 100 MHz)
- `clk_fpga`  in  1  100 MHz master clock; the block's only clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  N_CH  per-channel enable, level-sensitive
- `sync_all`  in  1  one-cycle request to restart all enabled channels in phase
- `cfg_we`  in  1  configuration write strobe
- `cfg_ch`  in  $clog2(N_CH) (min 1)  channel addressed by the write
- `cfg_half`  in  CNT_W  new half-period H
- `cfg_mode`  in  1  0 = CLOCK (clk_out toggles), 1 = PULSE (clk_out held 0)
- `clk_out`  out  N_CH  divided clock, period 2·H cycles, registered
- `tick`  out  N_CH  one-cycle pulse every H cycles, registered

## Operation
- Per channel: active regs `half_q` and `mode_q`, shadow regs `half_sh` and `mode_sh`, counter `cnt` (CNT_W), output regs `clk_q` and `tick_q`.
- Reset: `half_q = half_sh = DEFAULT_HALF`, `mode = CLOCK`, `cnt = 0`, `clk_out = 0`, `tick = 0`.
- Channel is ACTIVE when `en[i] = 1` and `half_q ≠ 0`; otherwise IDLE.
- IDLE: `cnt <= 0`, `clk_q <= 0`, `tick_q <= 0`. A config write lands in shadow and active together (immediate).
- ACTIVE, `cnt ≠ H−1`: `cnt <= cnt + 1`, `tick_q <= 0`.
- ACTIVE, terminal count (`cnt == H−1`):
  - `cnt <= 0`, `tick_q <= 1`.
  - `clk_q <= ~clk_q` in CLOCK mode; `clk_q <= 0` in PULSE mode.
  - Active regs load from shadow.
- Config write while ACTIVE updates shadow only. It takes effect at the next terminal count, so no runt periods.
- Write coinciding with terminal count: the written value is loaded at that edge (shadow bypass).
- Write to `cfg_ch ≥ N_CH`: ignored.
- H = 1: tick high every cycle; clk_out toggles every cycle.
- H = 0 written: channel goes IDLE at its next terminal count (or immediately if already IDLE).
- `sync_all`, each ACTIVE channel: `cnt <= 0`, `clk_q <= 0`, `tick_q <= 0`, active regs load from shadow. Has priority over terminal count and over a same-cycle write's bypass; the write still lands in shadow.
- `en[i]` falling: channel IDLE on the next edge; the output drops to 0 within 1 cycle, even mid-period.
- `rst` overrides everything, including a same-cycle `cfg_we`.
- Counter never exceeds H−1; no arithmetic wrap beyond CNT_W.

## Timing
- Inputs sampled on the rising edge of `clk_fpga`; all outputs come straight from flops.
- `en` rises at edge E: counting starts at E. First tick and first clk_out rise are visible after edge E+H.
- Steady CLOCK mode: clk_out high H cycles, low H cycles; tick coincides with every clk_out edge.
- `sync_all` at edge S: all channels restart together. Each channel's first tick is after edge S+H_i.

## Structure
- Shared package `clk_div_pkg`: `MODE_CLOCK` / `MODE_PULSE` constants, `DEFAULT_HALF` value, per-channel config struct {half, mode}.
- Sub-module `clk_div_channel` (one channel: counter, shadow/active regs, outputs), instantiated N_CH times by a generate loop. The top holds only write decode and fan-out of `sync_all`.

## Test plan
- Reset, `en = 4'b0001`, default H = 50_000 → `clk_out[0]` period 100_000 cycles, 50 % duty; ticks 50_000 apart; other channels stay 0.
- ch1: write H = 3 CLOCK while IDLE, then enable → ticks at cycles 3, 6, 9; clk_out[1] high cycles 3–5, low 6–8.
- ch1 ACTIVE H = 3: write H = 5 at `cnt = 1` → the current period still ends at 3, then ticks every 5. Repeat with the write at `cnt = 2` → the new H applies at that same terminal count.
- ch2: PULSE mode, H = 1 → tick constantly 1, clk_out[2] constantly 0; switch to CLOCK H = 1 → clk_out toggles every cycle.
- ch0 H = 4, ch1 H = 6 free-running, assert `sync_all` → both outputs 0 next cycle; ch0 ticks 4 cycles later, ch1 ticks 6 cycles later.
- Deassert `en[3]` mid-high-phase → clk_out[3] = 0 next cycle. Assert `rst` together with `cfg_we` → all channels return to DEFAULT_HALF and outputs 0.
